// File: rtl/axis_pkt_meter.sv
// AXI4-Stream pass-through with a 2-entry skid register and one byte-length descriptor per packet.
// Define AXIS_PKT_METER_BEATS_EN to add the m_len_beats beat-count descriptor field.

module axis_pkt_meter #(
  parameter int DATA_BITS = 512,
  parameter int LEN_BITS  = 32
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_len_valid,
  input  logic                   m_len_ready,
  output logic [LEN_BITS-1:0]    m_len_bytes,
`ifdef AXIS_PKT_METER_BEATS_EN
  output logic [LEN_BITS-1:0]    m_len_beats,
`endif
  output logic                   m_len_ovf
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int CNT_BITS  = $clog2(KEEP_BITS + 1);
  localparam int SUM_BITS  = ((LEN_BITS > CNT_BITS) ? LEN_BITS : CNT_BITS) + 1;
  localparam logic [LEN_BITS-1:0] LEN_MAX = '1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
  } beat_t;

  logic [1:0]          state_q, state_d;
  logic                tready_q;
  beat_t               main_q, main_d, skid_q, skid_d, s_beat;
  logic                stall, s_fire, m_fire;

  logic [CNT_BITS-1:0] keep_cnt;
  logic [SUM_BITS-1:0] sum_bytes;
  logic                bytes_sat, pkt_sat;
  logic [LEN_BITS-1:0] next_bytes;
  logic [LEN_BITS-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                desc_valid_q, desc_valid_d;
  logic [LEN_BITS-1:0] desc_bytes_q, desc_bytes_d;
  logic                desc_ovf_q, desc_ovf_d;
`ifdef AXIS_PKT_METER_BEATS_EN
  logic                beats_sat;
  logic [LEN_BITS-1:0] next_beats;
  logic [LEN_BITS-1:0] beats_q, beats_d;
  logic [LEN_BITS-1:0] desc_beats_q, desc_beats_d;
`endif

  // A full descriptor register only blocks the beat that would produce the next descriptor.
  assign stall         = desc_valid_q & ~m_len_ready & s_axis_tlast;
  assign s_axis_tready = tready_q & ~stall;
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign m_fire        = m_axis_tvalid & m_axis_tready;
  assign s_beat        = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};

  assign m_axis_tvalid = (state_q != ST_EMPTY);
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tkeep  = main_q.keep;
  assign m_axis_tlast  = main_q.last;

  assign m_len_valid   = desc_valid_q;
  assign m_len_bytes   = desc_bytes_q;
  assign m_len_ovf     = desc_ovf_q;
`ifdef AXIS_PKT_METER_BEATS_EN
  assign m_len_beats   = desc_beats_q;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (s_fire) begin
        main_d  = s_beat;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        if (s_fire && !m_fire) begin
          skid_d  = s_beat;
          state_d = ST_TWO;
        end else if (m_fire && !s_fire) begin
          state_d = ST_EMPTY;
        end else if (s_fire && m_fire) begin
          main_d  = s_beat;
        end
      end
      ST_TWO: if (m_fire) begin
        main_d  = skid_q;
        state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_BITS; i++) keep_cnt = keep_cnt + CNT_BITS'(s_axis_tkeep[i]);
  end

  assign sum_bytes  = SUM_BITS'(acc_q) + SUM_BITS'(keep_cnt);
  assign bytes_sat  = sum_bytes > SUM_BITS'(LEN_MAX);
  assign next_bytes = bytes_sat ? LEN_MAX : sum_bytes[LEN_BITS-1:0];
`ifdef AXIS_PKT_METER_BEATS_EN
  assign beats_sat  = (beats_q == LEN_MAX);
  assign next_beats = beats_sat ? LEN_MAX : beats_q + LEN_BITS'(1);
  assign pkt_sat    = bytes_sat | beats_sat;
`else
  assign pkt_sat    = bytes_sat;
`endif

  always_comb begin
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    desc_valid_d = desc_valid_q;
    desc_bytes_d = desc_bytes_q;
    desc_ovf_d   = desc_ovf_q;
`ifdef AXIS_PKT_METER_BEATS_EN
    beats_d      = beats_q;
    desc_beats_d = desc_beats_q;
`endif
    if (desc_valid_q && m_len_ready) desc_valid_d = 1'b0;
    if (s_fire) begin
      if (s_axis_tlast) begin
        desc_valid_d = 1'b1;
        desc_bytes_d = next_bytes;
        desc_ovf_d   = ovf_q | pkt_sat;
        acc_d        = '0;
        ovf_d        = 1'b0;
`ifdef AXIS_PKT_METER_BEATS_EN
        desc_beats_d = next_beats;
        beats_d      = '0;
`endif
      end else begin
        acc_d        = next_bytes;
        ovf_d        = ovf_q | pkt_sat;
`ifdef AXIS_PKT_METER_BEATS_EN
        beats_d      = next_beats;
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      tready_q     <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_bytes_q <= '0;
      desc_ovf_q   <= 1'b0;
`ifdef AXIS_PKT_METER_BEATS_EN
      beats_q      <= '0;
      desc_beats_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tready_q     <= (state_d != ST_TWO);
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      desc_valid_q <= desc_valid_d;
      desc_bytes_q <= desc_bytes_d;
      desc_ovf_q   <= desc_ovf_d;
`ifdef AXIS_PKT_METER_BEATS_EN
      beats_q      <= beats_d;
      desc_beats_q <= desc_beats_d;
`endif
    end
  end

  // NOTE: payload registers are qualified by state_q, so they carry no reset.
  always_ff @(posedge aclk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule
